// File: rtl/div_pkg.sv
// div_pkg: shared types and op-field bit positions for the iterative divider
package div_pkg;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } div_state_t;

    // op[0] set means unsigned, op[1] set means remainder
    localparam int DIV_OP_IS_SIGNED = 0;
    localparam int DIV_OP_IS_REM    = 1;

endpackage

// File: rtl/div_unit.sv
// div_unit: iterative RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per cycle
module div_unit
    import div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  div_op_t         op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic sgn);
        return (sgn && x[XLEN-1]) ? -x : x;
    endfunction

    function automatic logic [XLEN-1:0] fix_sign(input logic [XLEN-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

    div_state_t      state_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvsr_q;
    logic [XLEN-1:0] result_q;
    logic            done_q;
    logic            is_rem_q;
    logic            neg_quo_q;
    logic            neg_rem_q;

    logic            op_signed, op_rem, div_zero, ovf, special, accept;
    logic [XLEN-1:0] special_res, run_res;
    logic [XLEN:0]   shifted, trial;

    assign op_signed   = ~op[DIV_OP_IS_SIGNED];
    assign op_rem      = op[DIV_OP_IS_REM];
    assign div_zero    = (divisor == '0);
    assign ovf         = op_signed && (dividend == MIN_NEG) && (divisor == '1);
    assign special     = div_zero || ovf;
    assign special_res = div_zero ? (op_rem ? dividend : '1) : (op_rem ? '0 : MIN_NEG);
    assign accept      = (state_q == IDLE) && start && !abort;

    // combinational stall term covers the cycle the op enters EX
    assign busy   = rst_n && (accept || (state_q == RUN));
    assign done   = done_q;
    assign result = result_q;

    // one restoring shift-subtract step plus the sign-fixed result it would produce
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        trial   = shifted - {1'b0, dvsr_q};
        rem_d   = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
        quo_d   = {quo_q[XLEN-2:0], ~trial[XLEN]};
        cnt_d   = cnt_q + 1'b1;
        run_res = is_rem_q ? fix_sign(rem_d, neg_rem_q) : fix_sign(quo_d, neg_quo_q);
    end

    // control FSM with datapath registers and registered done/result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cnt_q     <= '0;
                        rem_q     <= '0;
                        quo_q     <= mag(dividend, op_signed);
                        dvsr_q    <= mag(divisor, op_signed);
                        is_rem_q  <= op_rem;
                        neg_quo_q <= op_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
                        neg_rem_q <= op_signed && dividend[XLEN-1];
                        if (special) begin
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            result_q <= special_res;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_q <= IDLE;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_d;
                        if (cnt_d == CW'(XLEN)) begin
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            result_q <= run_res;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit
module tb_div_unit;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    div_op_t     op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_res;

    div_unit #(.XLEN(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .op(op),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives one op from cycle 0 (inputs set just after a rising edge) and leaves start high
    // for one cycle past DONE so a following call exercises back-to-back issue.
    task automatic run_div(input string tag, input div_op_t o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int lat);
        int n;
        int bcnt;
        op = o;
        dividend = a;
        divisor = b;
        start = 1'b1;
        n = 0;
        bcnt = 0;
        #3;
        while (!done && n < 100) begin
            if (busy) bcnt++;
            @(posedge clk);
            #3;
            n++;
        end
        check({tag, " done_cycle"}, 32'(n), 32'(lat));
        check({tag, " busy_cycles"}, 32'(bcnt), 32'(lat));
        check({tag, " result"}, result, exp);
        check({tag, " busy_at_done"}, {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
        check({tag, " done_pulse"}, {31'b0, done}, 32'd0);
        check({tag, " result_hold"}, result, exp);
        last_res = exp;
    endtask

    initial begin
        int dcnt;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        op = DIV_OP_DIVU;
        dividend = '0;
        divisor = '0;
        last_res = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset result", result, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle busy", {31'b0, busy}, 32'd0);

        run_div("divu_100_7", DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
        run_div("remu_100_7", DIV_OP_REMU, 32'd100, 32'd7, 32'd2, 33);
        run_div("div_m100_7", DIV_OP_DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 33);
        run_div("rem_m100_7", DIV_OP_REM, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 33);
        run_div("rem_100_m7", DIV_OP_REM, 32'd100, 32'hFFFFFFF9, 32'd2, 33);
        run_div("div_5_0", DIV_OP_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
        run_div("remu_5_0", DIV_OP_REMU, 32'd5, 32'd0, 32'd5, 1);
        run_div("div_ovf", DIV_OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_div("rem_ovf", DIV_OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
        run_div("divu_ffff_1", DIV_OP_DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 33);
        start = 1'b0;

        // abort in RUN cycle 10
        @(posedge clk);
        #1;
        op = DIV_OP_DIVU;
        dividend = 32'd1000;
        divisor = 32'd3;
        start = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        abort = 1'b1;
        start = 1'b0;
        #3;
        check("abort busy_run", {31'b0, busy}, 32'd1);
        @(posedge clk);
        #1;
        abort = 1'b0;
        #3;
        check("abort busy_drop", {31'b0, busy}, 32'd0);
        check("abort result_kept", result, last_res);
        dcnt = 0;
        repeat (40) begin
            @(posedge clk);
            #3;
            if (done || busy) dcnt++;
        end
        check("abort no_done", 32'(dcnt), 32'd0);
        @(posedge clk);
        #1;
        run_div("after_abort", DIV_OP_DIVU, 32'd1000, 32'd3, 32'd333, 33);
        run_div("div_neg_neg", DIV_OP_DIV, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 33);
        start = 1'b0;

        // reset in RUN cycle 20
        @(posedge clk);
        #1;
        op = DIV_OP_DIVU;
        dividend = 32'h12345678;
        divisor = 32'd3;
        start = 1'b1;
        repeat (20) @(posedge clk);
        #3;
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        check("rst busy", {31'b0, busy}, 32'd0);
        check("rst done", {31'b0, done}, 32'd0);
        check("rst result", result, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        dcnt = 0;
        repeat (40) begin
            @(posedge clk);
            #3;
            if (done || busy) dcnt++;
        end
        check("rst no_done", 32'(dcnt), 32'd0);
        @(posedge clk);
        #1;
        run_div("after_rst", DIV_OP_DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 33);
        start = 1'b0;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
